// File: rtl/pal_scanout_sequencer.sv
// PAL frame/line scheduler: 625-line tick/line counters, line classification, per-line BRAM
// row fetch and 1 bpp pixel shifter. Define PAL_TEST_PATTERN_EN to add i_test_pattern bars.
module pal_scanout_sequencer #(
    parameter int unsigned LINE_TICKS = 10176,
    parameter int unsigned HALF_TICKS = 5088,
    parameter int unsigned T_FP       = 262,
    parameter int unsigned T_SYNC     = 747,
    parameter int unsigned T_BP       = 890,
    parameter int unsigned T_LONG     = 4341,
    parameter int unsigned T_SHORT    = 374,
    parameter int unsigned PIXELS     = 300,
    parameter int unsigned PIX_TICKS  = 27
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_enable,
`ifdef PAL_TEST_PATTERN_EN
    input  logic              i_test_pattern,
`endif
    output logic              o_bram_rd_en,
    output logic [9:0]        o_bram_addr,
    input  logic [PIXELS-1:0] i_bram_data,
    output logic [1:0]        o_level,
    output logic [9:0]        o_line,
    output logic              o_field,
    output logic              o_frame_start
);

    localparam int unsigned TW = $clog2(LINE_TICKS);
    localparam int unsigned PW = (PIX_TICKS > 1) ? $clog2(PIX_TICKS) : 1;

    localparam logic [TW-1:0] LastTick  = TW'(LINE_TICKS - 1);
    localparam logic [TW-1:0] HalfTick  = TW'(HALF_TICKS);
    localparam logic [TW-1:0] LongEnd   = TW'(T_LONG);
    localparam logic [TW-1:0] ShortEnd  = TW'(T_SHORT);
    localparam logic [TW-1:0] FpEnd     = TW'(T_FP);
    localparam logic [TW-1:0] SyncEnd   = TW'(T_FP + T_SYNC);
    localparam logic [TW-1:0] ActStart  = TW'(T_FP + T_SYNC + T_BP);
    localparam logic [TW-1:0] ActEnd    = TW'(T_FP + T_SYNC + T_BP + PIXELS * PIX_TICKS);
    localparam logic [TW-1:0] FetchTick = TW'(2);
    localparam logic [PW-1:0] PixLast   = PW'(PIX_TICKS - 1);

    localparam logic [1:0] LvlLow   = 2'd0;
    localparam logic [1:0] LvlBlack = 2'd1;
    localparam logic [1:0] LvlWhite = 2'd2;

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef enum logic [2:0] {LnNormal, LnLongLong, LnLongShort, LnShortLong, LnShortShort} kind_e;

    function automatic logic is_visible(input logic [9:0] l);
        return (l >= 10'd23 && l <= 10'd310) || (l >= 10'd336 && l <= 10'd623);
    endfunction

    // Even rows go to the first field, odd rows to the second.
    function automatic logic [9:0] row_of(input logic [9:0] l);
        if (l <= 10'd310) return (l - 10'd23) << 1;
        return ((l - 10'd336) << 1) | 10'd1;
    endfunction

    state_e            state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [9:0]        line_q, line_d;
    logic [1:0]        level_q, level_d;
    logic              rd_en_q, rd_en_d;
    logic [9:0]        addr_q, addr_d;
    logic              field_q, field_d;
    logic              frame_start_q, frame_start_d;
    logic [PIXELS-1:0] shift_q, shift_d;
    logic [PW-1:0]     pix_q, pix_d;

    kind_e             kind;
    logic              second_half, long_half, in_active, use_bram, pix_bit;
    logic [TW-1:0]     htick;

`ifdef PAL_TEST_PATTERN_EN
    logic [9:0] pix_idx_q, pix_idx_d;

    assign use_bram = !i_test_pattern;
    assign pix_bit  = i_test_pattern ? pix_idx_q[5] : shift_q[0];

    always_comb begin
        pix_idx_d = pix_idx_q;
        if (!in_active) pix_idx_d = '0;
        else if (pix_q == PixLast) pix_idx_d = pix_idx_q + 10'd1;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) pix_idx_q <= '0;
        else       pix_idx_q <= pix_idx_d;
    end
`else
    assign use_bram = 1'b1;
    assign pix_bit  = shift_q[0];
`endif

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q       <= StIdle;
            tick_q        <= '0;
            line_q        <= 10'd1;
            level_q       <= LvlLow;
            rd_en_q       <= 1'b0;
            addr_q        <= '0;
            field_q       <= 1'b0;
            frame_start_q <= 1'b0;
            shift_q       <= '0;
            pix_q         <= '0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            line_q        <= line_d;
            level_q       <= level_d;
            rd_en_q       <= rd_en_d;
            addr_q        <= addr_d;
            field_q       <= field_d;
            frame_start_q <= frame_start_d;
            shift_q       <= shift_d;
            pix_q         <= pix_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        line_d  = line_q;
        unique case (state_q)
            StIdle: if (i_enable) state_d = StRun;
            StRun: begin
                if (tick_q == LastTick) begin
                    tick_d = '0;
                    if (line_q == 10'd625) begin
                        line_d = 10'd1;
                        if (!i_enable) state_d = StIdle;
                    end else begin
                        line_d = line_q + 10'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        case (line_q)
            10'd1, 10'd2, 10'd314, 10'd315: kind = LnLongLong;
            10'd3:                           kind = LnLongShort;
            10'd313:                         kind = LnShortLong;
            10'd4, 10'd5, 10'd311, 10'd312, 10'd316, 10'd317,
            10'd623, 10'd624, 10'd625:       kind = LnShortShort;
            default:                         kind = LnNormal;
        endcase
    end

    assign second_half = tick_q >= HalfTick;
    assign htick       = second_half ? tick_q - HalfTick : tick_q;
    assign long_half   = (kind == LnLongLong) || (kind == LnLongShort && !second_half) ||
                         (kind == LnShortLong && second_half);
    assign in_active   = (state_q == StRun) && (tick_q >= ActStart) && (tick_q < ActEnd);

    always_comb begin
        level_d       = LvlBlack;
        rd_en_d       = 1'b0;
        addr_d        = addr_q;
        shift_d       = shift_q;
        pix_d         = '0;
        field_d       = line_d >= 10'd313;
        frame_start_d = (state_d == StRun) && (tick_d == '0) && (line_d == 10'd1);

        // Look ahead so the strobe coincides with tick 0 of the visible line.
        if (state_d == StRun && tick_d == '0 && is_visible(line_d) && use_bram) begin
            rd_en_d = 1'b1;
            addr_d  = row_of(line_d);
        end

        if (state_q == StRun) begin
            if (kind != LnNormal) begin
                level_d = (htick < (long_half ? LongEnd : ShortEnd)) ? LvlLow : LvlBlack;
            end else if (tick_q >= FpEnd && tick_q < SyncEnd) begin
                level_d = LvlLow;
            end else if (in_active && is_visible(line_q) && pix_bit) begin
                level_d = LvlWhite;
            end

            if (tick_q == FetchTick && is_visible(line_q) && use_bram) shift_d = i_bram_data;

            if (in_active) begin
                if (pix_q == PixLast) shift_d = shift_q >> 1;
                else                  pix_d   = pix_q + PW'(1);
            end
        end
    end

    assign o_bram_rd_en  = rd_en_q;
    assign o_bram_addr   = addr_q;
    assign o_level       = level_q;
    assign o_line        = line_q;
    assign o_field       = field_q;
    assign o_frame_start = frame_start_q;

endmodule
